// File: rtl/maxpool_row_pair_buffer.sv
// -----------------------------------------------------------------------------
// maxpool_row_pair_buffer
//
// Purpose:
//   Collects two consecutive image rows of D-channel pixels, which arrive one
//   pixel per cycle in raster order, into a single wide word. The word is then
//   handed to the 2x2 max-pooling stage. The block also counts row pairs inside
//   an H-row frame and flags the last pair of each frame.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid && ready are both high.
//   - The producer holds valid, and its data stable, until the transfer.
//   - ready may be high with valid low; nothing is transferred in that case.
//   - The data lines are ignored whenever valid or ready is low.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    in_data carries a pixel
//   in_ready    block accepts a pixel this cycle (high only while filling)
//   in_data     one pixel; channel c at [c*DATA_BITS +: DATA_BITS]
//   out_valid   out_data carries a complete row pair
//   out_ready   downstream consumes the pair this cycle
//   out_data    row pair; channel c of pixel j in row r at
//               ((r*W + j)*D + c)*DATA_BITS
//   pair_index  index of the pair on out_data, 0..H/2-1
//   frame_last  high with out_valid on the last pair of a frame
//
// Debug visibility:
//   The two-state FSM is held in state_q. in_ready and out_valid are direct
//   decodes of state_q, so the state can be observed from either output.
// -----------------------------------------------------------------------------
module maxpool_row_pair_buffer #(
  parameter int DATA_BITS = 32,
  parameter int D         = 32,
  parameter int W         = 92,
  parameter int H         = 92,
  localparam int PIDX_W   = ((H / 2) > 1) ? $clog2(H / 2) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D*DATA_BITS-1:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*W*D*DATA_BITS-1:0]   out_data,
  output logic [PIDX_W-1:0]            pair_index,
  output logic                         frame_last
);

  localparam int PIX_W  = D * DATA_BITS;
  localparam int NSLOT  = 2 * W;
  localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
  localparam int SIDX_W = $clog2(NSLOT);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(W - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(H / 2 - 1);
  localparam logic [SIDX_W-1:0] ROW1_BASE = SIDX_W'(W);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               row_sel_q, row_sel_d;
  logic [PIDX_W-1:0]  pidx_q, pidx_d;
  logic [PIX_W-1:0]   slots_q [NSLOT];
  logic [PIX_W-1:0]   slots_d [NSLOT];

  logic [SIDX_W-1:0]  slot_idx;
  logic               pix_accept;
  logic               pair_accept;

  // Slot address: upper row occupies slots 0..W-1, lower row W..2W-1.
  assign slot_idx    = (row_sel_q ? ROW1_BASE : '0) + SIDX_W'(col_q);

  // Both handshake outputs come straight from the state register. This keeps
  // in_ready free of any combinational path from out_ready.
  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == FULL);
  assign pix_accept  = in_valid && in_ready;
  assign pair_accept = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_sel_d = row_sel_q;
    pidx_d    = pidx_q;
    slots_d   = slots_q;

    case (state_q)
      FILL: begin
        if (pix_accept) begin
          slots_d[slot_idx] = in_data;
          if (col_q == COL_LAST) begin
            col_d     = '0;
            row_sel_d = ~row_sel_q;
            // Writing the last slot of the lower row completes the pair.
            if (row_sel_q) begin
              state_d = FULL;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      FULL: begin
        if (pair_accept) begin
          state_d = FILL;
          pidx_d  = (pidx_q == PIDX_LAST) ? '0 : pidx_q + PIDX_W'(1);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      col_q     <= '0;
      row_sel_q <= 1'b0;
      pidx_q    <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_sel_q <= row_sel_d;
      pidx_q    <= pidx_d;
      slots_q   <= slots_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The slot array index order already matches the out_data layout. Slots are
  // not cleared between pairs; every slot is rewritten before the next FULL.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NSLOT; i++) begin
      out_data[i*PIX_W +: PIX_W] = slots_q[i];
    end
  end

  assign pair_index = pidx_q;
  assign frame_last = (state_q == FULL) && (pidx_q == PIDX_LAST);

endmodule

// File: tb/tb_maxpool_row_pair_buffer.sv
// -----------------------------------------------------------------------------
// tb_maxpool_row_pair_buffer
//
// Directed bench for maxpool_row_pair_buffer at W=4, H=4, D=2, DATA_BITS=8.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, so every sample sits half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_maxpool_row_pair_buffer;

  localparam int DATA_BITS = 8;
  localparam int D         = 2;
  localparam int W         = 4;
  localparam int H         = 4;
  localparam int PIX_W     = D * DATA_BITS;
  localparam int OUT_W     = 2 * W * PIX_W;
  localparam int PIDX_W    = 1;
  localparam int NPIX      = 2 * W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PIX_W-1:0]   in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OUT_W-1:0]   out_data;
  logic [PIDX_W-1:0]  pair_index;
  logic               frame_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maxpool_row_pair_buffer #(
    .DATA_BITS (DATA_BITS),
    .D         (D),
    .W         (W),
    .H         (H)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .pair_index (pair_index),
    .frame_last (frame_last)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pixel k of pair p: channel c holds byte 16*p + 2*k + c.
  function automatic logic [PIX_W-1:0] pix(input int p, input int k);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'(16 * p + 2 * k);
    hi = 8'(16 * p + 2 * k + 1);
    return {hi, lo};
  endfunction

  // Hand-derived pair word: byte n of pair p is 16*p + n.
  function automatic logic [OUT_W-1:0] pair_word(input int p);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int n = 0; n < OUT_W / 8; n++) begin
      v[n*8 +: 8] = 8'(16 * p + n);
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one pixel and returns at the falling edge after it was accepted.
  task automatic send_pixel(input logic [PIX_W-1:0] px);
    int waited;
    in_valid = 1'b1;
    in_data  = px;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {{(OUT_W-1){1'b0}}, in_ready}, {{(OUT_W-1){1'b0}}, 1'b1});
    end
    @(negedge clk);
  endtask

  // Streams one pair (optionally with random gaps) and checks the result.
  task automatic run_pair(input int p, input bit gapped,
                          input logic [PIDX_W-1:0] exp_pidx);
    for (int k = 0; k < NPIX; k++) begin
      if (gapped) begin
        repeat ($urandom_range(0, 1)) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      if (k == NPIX - 1) begin
        check("pre_full_out_valid", OUT_W'(out_valid), OUT_W'(0));
      end
      send_pixel(pix(p, k));
    end
    in_valid = 1'b0;
    exp_q.push_back(pair_word(p));
    check("full_out_valid", OUT_W'(out_valid), OUT_W'(1));
    check("full_in_ready", OUT_W'(in_ready), OUT_W'(0));
    check("pair_index", OUT_W'(pair_index), OUT_W'(exp_pidx));
    check("frame_last", OUT_W'(frame_last), OUT_W'(exp_pidx == PIDX_W'(H / 2 - 1)));
    check("out_data", out_data, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("rst_pair_index", OUT_W'(pair_index), OUT_W'(0));
    check("rst_frame_last", OUT_W'(frame_last), OUT_W'(0));
    check("rst_out_data", out_data, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", OUT_W'(in_ready), OUT_W'(1));

    // Single pair, out_ready low
    run_pair(0, 1'b0, 1'b0);

    // Backpressure: upstream keeps offering a pixel that must not be taken
    in_valid = 1'b1;
    in_data  = 16'hEEEE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", OUT_W'(out_valid), OUT_W'(1));
      check("bp_in_ready", OUT_W'(in_ready), OUT_W'(0));
      check("bp_out_data", out_data, pair_word(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("release_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("release_pair_index", OUT_W'(pair_index), OUT_W'(1));
    check("release_frame_last", OUT_W'(frame_last), OUT_W'(0));

    // Second pair of the frame; EEEE must not have been absorbed
    run_pair(1, 1'b0, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("wrap_pair_index", OUT_W'(pair_index), OUT_W'(0));
    check("wrap_out_valid", OUT_W'(out_valid), OUT_W'(0));

    // Frame wrap, back-to-back with out_ready held high
    do_reset();
    out_ready = 1'b1;
    run_pair(0, 1'b0, 1'b0);
    run_pair(1, 1'b0, 1'b1);
    @(negedge clk);
    check("fw_next_pair_index", OUT_W'(pair_index), OUT_W'(0));
    check("fw_next_frame_last", OUT_W'(frame_last), OUT_W'(0));
    check("fw_next_in_ready", OUT_W'(in_ready), OUT_W'(1));

    // Gapped input across a frame: contents must match the back-to-back run
    do_reset();
    out_ready = 1'b1;
    run_pair(0, 1'b1, 1'b0);
    run_pair(1, 1'b1, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;

    // Mid-fill reset after 5 pixels, then 8 fresh pixels
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_pixel(16'hF000 | 16'(k));
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_pair(0, 1'b0, 1'b0);

    // Reset while FULL drops the pending pair at once
    reset_n = 1'b0;
    #1;
    check("fullrst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("fullrst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("fullrst_pair_index", OUT_W'(pair_index), OUT_W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
